cache_refill: RTL and testbench

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_refill_pkg.sv | 58 +++++
 rtl/cache_wbuf.sv | 60 ++++++
 rtl/cache_refill.sv | 213 +++++++++++++++++++++
 tb/tb_cache_refill.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_pkg.sv
// -----------------------------------------------------------------------------
// cache_refill_pkg
// Shared CPU definitions: instruction opcodes, register-file sizing, and the
// refill engine's state encoding and line-offset constants.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_refill_pkg;

  // ---------------------------------------------------------------------------
  // CPU-wide defines
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_LD  = 4'h5,
    OP_ST  = 4'h6,
    OP_BEQ = 4'h7,
    OP_JMP = 4'h8,
    OP_NOP = 4'hF
  } opcode_e;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  // ---------------------------------------------------------------------------
  // Data-cache refill engine
  // ---------------------------------------------------------------------------
  localparam int WORD_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int TAG_W      = 8;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;

  // Word offsets within a line; offset 0 sits in the most significant slot.
  localparam logic [1:0] OFF_W0   = 2'd0;
  localparam logic [1:0] OFF_W1   = 2'd1;
  localparam logic [1:0] OFF_W2   = 2'd2;
  localparam logic [1:0] OFF_W3   = 2'd3;
  localparam logic [1:0] OFF_LAST = OFF_W3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAST = 3'd2,
    ST_DONE = 3'd3,
    ST_WR   = 3'd4
  } fill_state_e;

  // LSB position of a word's slot inside the assembled line:
  // offset 0 -> 48, 1 -> 32, 2 -> 16, 3 -> 0.
  function automatic logic [5:0] slot_lsb(input logic [1:0] off);
    return 6'd48 - {off, 4'b0000};
  endfunction

endpackage

// File: rtl/cache_wbuf.sv
// -----------------------------------------------------------------------------
// cache_wbuf
// One-entry write-through store buffer. A store is pushed when accepted and
// popped when the refill FSM starts the corresponding memory write.
//
// Ports
//   clock1  in   clock, rising edge
//   reset   in   asynchronous active-low reset (clears the full flag)
//   i_push  in   load i_addr/i_data and mark the entry full
//   i_addr  in   store word address
//   i_data  in   store data
//   i_pop   in   release the entry (write has been issued)
//   o_full  out  entry holds a store not yet written
//   o_addr  out  buffered address (meaningful while o_full)
//   o_data  out  buffered data    (meaningful while o_full)
// -----------------------------------------------------------------------------
module cache_wbuf
  import cache_refill_pkg::*;
(
  input  logic              clock1,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [WORD_W-1:0] o_data
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;

  // Push and pop are never requested together: a push needs the entry empty,
  // a pop needs it full.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only ever consumed while r_full is
  // set, and r_full alone decides whether the entry exists.
  always_ff @(posedge clock1) begin
    if (i_push) begin
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/cache_refill.sv
// -----------------------------------------------------------------------------
// cache_refill
// Data-cache line refill engine with a one-entry write-through store buffer.
// A load miss fetches the aligned 4-word line containing req_addr from data
// memory and presents it on tocache with a one-cycle line_valid pulse.
// Buffered stores always drain to memory before a new fill starts.
//
// Ports
//   clock1      in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   req_valid   in   load-miss fill request
//   req_addr    in   word address of the missing load
//   req_ready   out  fill request accepted when req_valid && req_ready
//   st_valid    in   write-through store request
//   st_addr     in   store word address
//   st_data     in   store data
//   st_ready    out  store accepted when st_valid && st_ready
//   mem_addr    out  data-memory word address (0 when no strobe)
//   mem_rd      out  read strobe; mem_rdata valid the following cycle
//   mem_wr      out  single-cycle write strobe
//   mem_wdata   out  write data (0 when no strobe)
//   mem_rdata   in   read data
//   tocache     out  assembled line, offset 0 in [63:48] .. offset 3 in [15:0]
//   line_tag    out  req_addr[15:8] of the current fill
//   line_valid  out  one-cycle pulse: tocache/line_tag hold a complete line
//   fill_count  out  completed fills since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module cache_refill
  import cache_refill_pkg::*;
(
  input  logic              clock1,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [WORD_W-1:0] st_data,
  output logic              st_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] tocache,
  output logic [TAG_W-1:0]  line_tag,
  output logic              line_valid,
  output logic [31:0]       fill_count
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  fill_state_e        r_state;
  logic [13:0]        r_base_hi;     // line-aligned base address, word bits [15:2]
  logic [1:0]         r_rd_off;      // offset of the read issued this cycle
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0]  r_mem_wdata;
  logic               r_line_valid;
  logic [TAG_W-1:0]   r_line_tag;
  logic [31:0]        r_fill_count;
  logic               r_cap_pend;    // a read was issued last cycle
  logic [1:0]         r_cap_off;     // its word offset
  logic [LINE_W-1:0]  r_tocache;

  logic               w_idle;
  logic               w_wb_full;
  logic               w_wb_push;
  logic               w_wb_pop;
  logic [ADDR_W-1:0]  w_wb_addr;
  logic [WORD_W-1:0]  w_wb_data;
  logic               w_unused_ok;

  // The low address bits only select a word inside the line; the whole line
  // is fetched regardless.
  assign w_unused_ok = &{1'b1, req_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Handshakes and write buffer
  // ---------------------------------------------------------------------------
  // A store presented in the same cycle as a fill request wins; the requester
  // keeps holding the fill, which then waits for the store to drain.
  assign w_idle    = (r_state == ST_IDLE);
  assign st_ready  = w_idle && !w_wb_full;
  assign req_ready = w_idle && !w_wb_full && !st_valid;
  assign w_wb_push = st_valid && st_ready;
  assign w_wb_pop  = w_idle && w_wb_full;

  cache_wbuf u_wbuf (
    .clock1 (clock1),
    .reset  (reset),
    .i_push (w_wb_push),
    .i_addr (st_addr),
    .i_data (st_data),
    .i_pop  (w_wb_pop),
    .o_full (w_wb_full),
    .o_addr (w_wb_addr),
    .o_data (w_wb_data)
  );

  // ---------------------------------------------------------------------------
  // Refill / write FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  // The strobes, address and write data default to zero every cycle and are
  // set only on the edge that enters a cycle needing them, so memory never
  // sees a stale address and rd/wr can never overlap.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_base_hi    <= '0;
      r_rd_off     <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
      r_fill_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; every register here must
      // see the pre-edge value of every other, and the defaults below are
      // overridden later in the block without ordering hazards.
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_line_valid <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_wb_full) begin
            r_state     <= ST_WR;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= w_wb_addr;
            r_mem_wdata <= w_wb_data;
          end else if (req_valid && req_ready) begin
            r_state    <= ST_RD;
            r_base_hi  <= req_addr[15:2];
            r_line_tag <= req_addr[15:8];
            r_rd_off   <= OFF_W0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= {req_addr[15:2], OFF_W0};
          end
        end

        ST_RD: begin
          if (r_rd_off == OFF_LAST) begin
            r_state <= ST_LAST;
          end else begin
            // Only the offset bits advance, so the line never wraps into the
            // next 4-word block.
            r_rd_off   <= r_rd_off + 2'd1;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= {r_base_hi, r_rd_off + 2'd1};
          end
        end

        // The final word is captured on this edge by the datapath below, so
        // the line is complete in the same cycle line_valid rises.
        ST_LAST: begin
          r_state      <= ST_DONE;
          r_line_valid <= 1'b1;
          r_fill_count <= r_fill_count + 32'd1;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        ST_WR: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line assembly: each read's data arrives the cycle after its strobe and is
  // dropped into the slot selected by the offset that was read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) begin
      r_cap_pend <= 1'b0;
      r_cap_off  <= '0;
      r_tocache  <= '0;
    end else begin
      r_cap_pend <= r_mem_rd;
      r_cap_off  <= r_mem_addr[1:0];
      if (r_cap_pend) begin
        r_tocache[slot_lsb(r_cap_off) +: WORD_W] <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_wdata  = r_mem_wdata;
  assign tocache    = r_tocache;
  assign line_tag   = r_line_tag;
  assign line_valid = r_line_valid;
  assign fill_count = r_fill_count;

endmodule

// File: tb/tb_cache_refill.sv
// -----------------------------------------------------------------------------
// tb_cache_refill
// Directed self-checking bench for cache_refill. A behavioural memory returns
// 16'hA000+offset for addresses 0x12xx and the bitwise inverse of the address
// otherwise; expected lines below are worked out by hand from that rule.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_cache_refill;

  logic        clock1    = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr  = '0;
  logic        req_ready;
  logic        st_valid  = 1'b0;
  logic [15:0] st_addr   = '0;
  logic [15:0] st_data   = '0;
  logic        st_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [63:0] tocache;
  logic [7:0]  line_tag;
  logic        line_valid;
  logic [31:0] fill_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Protocol monitors, evaluated every falling edge.
  int lv_count   = 0;
  int both_cnt   = 0;
  int idle_bad   = 0;
  int zero_acc   = 0;
  int strobe_cnt = 0;

  always #5 clock1 = ~clock1;

  cache_refill dut (
    .clock1     (clock1),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .tocache    (tocache),
    .line_tag   (line_tag),
    .line_valid (line_valid),
    .fill_count (fill_count)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (a[15:8] == 8'h12) return 16'hA000 + {14'd0, a[1:0]};
    return ~a;
  endfunction

  // Read data is valid the cycle after the strobe; a junk value otherwise so
  // a capture in the wrong cycle shows up in the line.
  always @(posedge clock1) begin
    mem_rdata <= mem_rd ? mem_fn(mem_addr) : 16'hDEAD;
  end

  always @(negedge clock1) begin
    if (line_valid) lv_count++;
    if (mem_rd && mem_wr) both_cnt++;
    if (!mem_rd && !mem_wr && (mem_addr != 16'h0 || mem_wdata != 16'h0)) idle_bad++;
    if ((mem_rd || mem_wr) && mem_addr == 16'h0) zero_acc++;
    if (mem_rd || mem_wr) strobe_cnt++;
  end

  task automatic tick();
    @(posedge clock1);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance until line_valid is seen (bounded); returns at that falling edge.
  task automatic wait_lv(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock1);
      if (line_valid) seen = 1'b1;
      else tick();
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  int lv0;
  int s0;

  initial begin
    // ---------------- reset state ----------------
    repeat (2) tick();
    @(negedge clock1);
    check("rst_tocache",  tocache,    64'h0);
    check("rst_tag",      64'(line_tag),   64'h0);
    check("rst_lv",       64'(line_valid), 64'h0);
    check("rst_count",    64'(fill_count), 64'h0);
    check("rst_mem_rd",   64'(mem_rd),     64'h0);
    check("rst_mem_wr",   64'(mem_wr),     64'h0);
    check("rst_mem_addr", 64'(mem_addr),   64'h0);
    check("rst_req_rdy",  64'(req_ready),  64'h1);
    check("rst_st_rdy",   64'(st_ready),   64'h1);
    tick();
    reset = 1'b1;
    tick();

    // ---------------- single fill, 0x1237 ----------------
    req_valid = 1'b1;
    req_addr  = 16'h1237;
    @(negedge clock1);
    check("t1_accept", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock1);
      check("t1_rd",   64'(mem_rd),   64'h1);
      check("t1_addr", 64'(mem_addr), 64'(16'h1234 + k));
      check("t1_lv_early", 64'(line_valid), 64'h0);
      tick();
    end
    @(negedge clock1);
    check("t1_last_rd", 64'(mem_rd),     64'h0);
    check("t1_last_lv", 64'(line_valid), 64'h0);
    tick();
    @(negedge clock1);
    check("t1_lv",      64'(line_valid), 64'h1);
    check("t1_line",    tocache,         64'hA000_A001_A002_A003);
    check("t1_tag",     64'(line_tag),   64'h12);
    tick();
    @(negedge clock1);
    check("t1_lv_off",  64'(line_valid), 64'h0);
    check("t1_count",   64'(fill_count), 64'h1);
    check("t1_hold",    tocache,         64'hA000_A001_A002_A003);
    tick();

    // ---------------- idle store 0x0040 <- 0xBEEF ----------------
    st_valid = 1'b1;
    st_addr  = 16'h0040;
    st_data  = 16'hBEEF;
    @(negedge clock1);
    check("t2_st_rdy", 64'(st_ready), 64'h1);
    tick();
    st_valid = 1'b0;
    @(negedge clock1);
    check("t2_full",     64'(st_ready), 64'h0);
    check("t2_no_wr",    64'(mem_wr),   64'h0);
    tick();
    @(negedge clock1);
    check("t2_wr",       64'(mem_wr),    64'h1);
    check("t2_wr_addr",  64'(mem_addr),  64'h0040);
    check("t2_wr_data",  64'(mem_wdata), 64'hBEEF);
    check("t2_wr_nord",  64'(mem_rd),    64'h0);
    tick();
    @(negedge clock1);
    check("t2_wr_off",   64'(mem_wr),    64'h0);
    check("t2_addr_off", 64'(mem_addr),  64'h0);
    check("t2_st_rdy2",  64'(st_ready),  64'h1);
    tick();

    // ---------------- simultaneous store + fill 0x0041 ----------------
    lv0       = lv_count;
    st_valid  = 1'b1;
    st_addr   = 16'h0050;
    st_data   = 16'h1234;
    req_valid = 1'b1;
    req_addr  = 16'h0041;
    @(negedge clock1);
    check("t3_st_rdy",   64'(st_ready),  64'h1);
    check("t3_req_blk",  64'(req_ready), 64'h0);
    tick();
    st_valid = 1'b0;
    @(negedge clock1);
    check("t3_req_blk2", 64'(req_ready), 64'h0);
    tick();
    @(negedge clock1);
    check("t3_wr",       64'(mem_wr),    64'h1);
    check("t3_wr_addr",  64'(mem_addr),  64'h0050);
    check("t3_wr_data",  64'(mem_wdata), 64'h1234);
    check("t3_req_blk3", 64'(req_ready), 64'h0);
    tick();
    @(negedge clock1);
    check("t3_accept",   64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock1);
      check("t3_rd",   64'(mem_rd),   64'h1);
      check("t3_addr", 64'(mem_addr), 64'(16'h0040 + k));
      tick();
    end
    wait_lv("t3_lv");
    check("t3_line", tocache,       64'hFFBF_FFBE_FFBD_FFBC);
    check("t3_tag",  64'(line_tag), 64'h00);
    repeat (4) tick();
    check("t3_lv_once", 64'(lv_count - lv0), 64'd1);

    // ---------------- top-of-memory fill 0xFFFF ----------------
    req_valid = 1'b1;
    req_addr  = 16'hFFFF;
    @(negedge clock1);
    check("t4_accept", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock1);
      check("t4_addr", 64'(mem_addr), 64'(16'hFFFC + k));
      tick();
    end
    wait_lv("t4_lv");
    check("t4_line", tocache,       64'h0003_0002_0001_0000);
    check("t4_tag",  64'(line_tag), 64'hFF);
    tick();

    // ---------------- back-to-back fills 0x0100, 0x0204 ----------------
    lv0       = lv_count;
    req_valid = 1'b1;
    req_addr  = 16'h0100;
    @(negedge clock1);
    check("t5_accept1", 64'(req_ready), 64'h1);
    tick();
    req_addr = 16'h0204;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock1);
      check("t5_busy", 64'(req_ready), 64'h0);
      tick();
    end
    @(negedge clock1);
    check("t5_lv1",    64'(line_valid), 64'h1);
    check("t5_line1",  tocache,         64'hFEFF_FEFE_FEFD_FEFC);
    check("t5_tag1",   64'(line_tag),   64'h01);
    check("t5_done_blk", 64'(req_ready), 64'h0);
    tick();
    @(negedge clock1);
    check("t5_accept2", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    @(negedge clock1);
    check("t5_rd2",    64'(mem_rd),   64'h1);
    check("t5_addr2",  64'(mem_addr), 64'h0204);
    wait_lv("t5_lv2");
    check("t5_line2",  tocache,       64'hFDFB_FDFA_FDF9_FDF8);
    check("t5_tag2",   64'(line_tag), 64'h02);
    repeat (2) tick();
    check("t5_count",  64'(fill_count),       64'd5);
    check("t5_lv_cnt", 64'(lv_count - lv0),   64'd2);

    // ---------------- reset in the middle of a fill ----------------
    req_valid = 1'b1;
    req_addr  = 16'h1237;
    @(negedge clock1);
    check("t6_accept", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_rd",    64'(mem_rd),     64'h0);
    check("t6_rst_wr",    64'(mem_wr),     64'h0);
    check("t6_rst_addr",  64'(mem_addr),   64'h0);
    check("t6_rst_wdata", 64'(mem_wdata),  64'h0);
    check("t6_rst_line",  tocache,         64'h0);
    check("t6_rst_tag",   64'(line_tag),   64'h0);
    check("t6_rst_lv",    64'(line_valid), 64'h0);
    check("t6_rst_count", 64'(fill_count), 64'h0);
    check("t6_rst_ready", 64'(req_ready),  64'h1);
    tick();
    tick();
    reset = 1'b1;
    lv0   = lv_count;
    s0    = strobe_cnt;
    repeat (10) tick();
    check("t6_no_lv",     64'(lv_count - lv0),   64'd0);
    check("t6_no_strobe", 64'(strobe_cnt - s0),  64'd0);
    check("t6_count",     64'(fill_count),       64'd0);

    // ---------------- whole-run protocol properties ----------------
    check("prop_rd_wr_excl", 64'(both_cnt), 64'd0);
    check("prop_idle_zero",  64'(idle_bad), 64'd0);
    check("prop_no_addr0",   64'(zero_acc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
